// File: rtl/nonce_result_scanner.sv
// nonce_result_scanner: streams NUM_NONCES hash words from memory and reports the minimum and its index.
// Ports: clk/reset_n (sync, active-low), start, output_addr (hash word base), target (threshold),
//        done (1-cycle pulse), found, best_nonce, best_hash (results, held until next start),
//        mem_clk/mem_we/mem_addr/mem_write_data/mem_read_data (memory with 2-cycle read latency).
// Optional macro SCANNER_WRITEBACK_EN: writes best_hash and {found, best_nonce} to RESULT_ADDR/RESULT_ADDR+1.
module nonce_result_scanner #(
    parameter int          NUM_NONCES  = 16,
    parameter logic [15:0] RESULT_ADDR = 16'h0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] output_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [5:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WB0, WB1, DONE} state_t;
    localparam logic [6:0] N = 7'(NUM_NONCES);
    state_t      state, state_nx;
    logic [6:0]  issue_cnt, cmp_cnt;
    logic [5:0]  rd_idx, cap_idx;
    logic        v1, v2, cap_v;
    logic [31:0] cap_data;
    logic        go, issuing;
    assign mem_clk = clk;
    assign done    = state == DONE;
    assign go      = state == IDLE && start;
    assign issuing = state == ISSUE && issue_cnt != N;
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = start ? ISSUE : IDLE;
            ISSUE: state_nx = issue_cnt == N ? DRAIN : ISSUE;
`ifdef SCANNER_WRITEBACK_EN
            DRAIN: state_nx = cmp_cnt == N ? WB0 : DRAIN;
`else
            DRAIN: state_nx = cmp_cnt == N ? DONE : DRAIN;
`endif
            WB0:   state_nx = WB1;
            WB1:   state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Read pipeline: v1/v2 track the two-cycle memory latency, cap_* holds the
    // returned word for one cycle so the compare happens on the following edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_addr   <= '0;
            issue_cnt  <= '0;
            cmp_cnt    <= '0;
            rd_idx     <= '0;
            cap_idx    <= '0;
            cap_data   <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            cap_v      <= 1'b0;
            found      <= 1'b0;
            best_nonce <= '0;
            best_hash  <= '1;
        end else begin
            v1       <= go || issuing;
            v2       <= v1;
            cap_v    <= v2;
            cap_data <= mem_read_data;
            cap_idx  <= rd_idx;
            if (v2) rd_idx <= rd_idx + 6'd1;
            if (issuing) begin
                mem_addr  <= mem_addr + 16'd1;
                issue_cnt <= issue_cnt + 7'd1;
            end
            if (cap_v) begin
                cmp_cnt <= cmp_cnt + 7'd1;
                if (cap_data < best_hash) begin
                    best_hash  <= cap_data;
                    best_nonce <= cap_idx;
                end
                if (cap_data < target) found <= 1'b1;
            end
`ifdef SCANNER_WRITEBACK_EN
            if (state == DRAIN && state_nx == WB0) mem_addr <= RESULT_ADDR;
            if (state == WB0) mem_addr <= RESULT_ADDR + 16'd1;
`endif
            if (go) begin
                mem_addr   <= output_addr;
                issue_cnt  <= 7'd1;
                cmp_cnt    <= '0;
                rd_idx     <= '0;
                found      <= 1'b0;
                best_nonce <= '0;
                best_hash  <= '1;
            end
        end
    end
`ifdef SCANNER_WRITEBACK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_we         <= 1'b0;
            mem_write_data <= '0;
        end else begin
            if (state == DRAIN && state_nx == WB0) begin
                mem_we         <= 1'b1;
                mem_write_data <= best_hash;
            end
            if (state == WB0) mem_write_data <= {found, 25'b0, best_nonce};
            if (state == WB1) mem_we <= 1'b0;
        end
    end
`else
    // RESULT_ADDR only matters with writeback; it is masked off here.
    assign mem_we         = 1'b0;
    assign mem_write_data = {16'h0, RESULT_ADDR & 16'h0};
`endif
endmodule

// File: tb/tb_nonce_result_scanner.sv
// tb_nonce_result_scanner: randomized and directed checks of nonce_result_scanner against a min/first-index model.
module tb_nonce_result_scanner;
    localparam int NN = 16;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] output_addr = '0;
    logic [31:0] target = '0;
    logic        done, found, mem_clk, mem_we;
    logic [5:0]  best_nonce;
    logic [31:0] best_hash, mem_write_data, mem_read_data;
    logic [15:0] mem_addr;
    logic [31:0] mem [65536];
    int checks = 0;
    int errors = 0;
    nonce_result_scanner dut (
        .clk(clk), .reset_n(reset_n), .start(start), .output_addr(output_addr), .target(target),
        .done(done), .found(found), .best_nonce(best_nonce), .best_hash(best_hash),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) mem_read_data <= mem[mem_addr];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask
    task automatic reset_vals(input string tag);
        chk({tag, ":done"}, 32'(done), 0);
        chk({tag, ":found"}, 32'(found), 0);
        chk({tag, ":nonce"}, 32'(best_nonce), 0);
        chk({tag, ":hash"}, best_hash, 32'hFFFFFFFF);
        chk({tag, ":we"}, 32'(mem_we), 0);
        chk({tag, ":addr"}, 32'(mem_addr), 0);
        chk({tag, ":wdata"}, mem_write_data, 0);
    endtask
    task automatic put(input logic [15:0] base, input int i, input logic [31:0] v);
        mem[16'(base + 16'(i))] = v;
    endtask
    // Model: best is the smallest word, reported at its first occurrence;
    // an all-FFFFFFFF block leaves index 0. found means the smallest word is below target.
    task automatic run_scan(input string tag, input logic [15:0] base, input logic [31:0] tgt, input int glitch);
        logic [31:0] mn;
        logic [31:0] en;
        logic        seen;
        int          dc, bad;
        mn = '1;
        for (int i = 0; i < NN; i++) if (mem[16'(base + 16'(i))] < mn) mn = mem[16'(base + 16'(i))];
        en = 0;
        seen = 1'b0;
        for (int i = 0; i < NN; i++)
            if (mn != 32'hFFFFFFFF && !seen && mem[16'(base + 16'(i))] == mn) begin
                en = i;
                seen = 1'b1;
            end
        output_addr = base;
        target = tgt;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bad = (mem_addr !== base) ? 1 : 0;
        dc = -1;
        for (int c = 1; c <= NN + 20 && dc < 0; c++) begin
            if (c == glitch) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            if (c < NN && mem_addr !== 16'(base + 16'(c))) bad++;
            if (done === 1'b1) dc = c;
        end
        chk({tag, ":addr_seq"}, 32'(bad), 0);
        chk({tag, ":latency"}, 32'(dc), NN + 3);
        chk({tag, ":found"}, 32'(found), 32'(mn < tgt));
        chk({tag, ":nonce"}, 32'(best_nonce), en);
        chk({tag, ":hash"}, best_hash, mn);
        @(posedge clk);
        #1 chk({tag, ":done_pulse"}, 32'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ":hold_nonce"}, 32'(best_nonce), en);
        chk({tag, ":hold_hash"}, best_hash, mn);
        chk({tag, ":hold_found"}, 32'(found), 32'(mn < tgt));
    endtask
    initial begin
        logic [15:0] b;
        int d1, d2;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        repeat (2) @(posedge clk);
        #1 reset_vals("reset");
        reset_n = 1'b1;
        for (int i = 0; i < NN; i++) put(16'h0200, i, 32'h1000_0000 + 32'((15 - i) * 16));
        run_scan("descending", 16'h0200, 32'h0800_0000, 0);
        for (int i = 0; i < NN; i++) put(16'h0300, i, i == 5 ? 32'h0000_00FF : 32'hFFFF_0000);
        run_scan("single_hit", 16'h0300, 32'h0001_0000, 0);
        for (int i = 0; i < NN; i++) put(16'h0400, i, (i == 3 || i == 9) ? 32'h0000_1234 : 32'h0000_5000 + 32'(i));
        run_scan("tie", 16'h0400, 32'h0000_1234, 0);
        for (int i = 0; i < NN; i++) put(16'h0500, i, 32'hFFFFFFFF);
        run_scan("all_ones", 16'h0500, 32'hFFFFFFFF, 0);
        for (int i = 0; i < NN; i++) put(16'hFFF8, i, 32'h2000_0000 - 32'(i));
        run_scan("wrap", 16'hFFF8, 32'h0, 0);
        run_scan("start_ignored", 16'h0300, 32'h0001_0000, 6);
        @(negedge clk) begin
            output_addr = 16'h0200;
            start = 1'b1;
        end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_vals("mid_reset");
        reset_n = 1'b1;
        run_scan("after_reset", 16'h0300, 32'h0001_0000, 0);
        for (int k = 0; k < 6; k++) begin
            b = 16'($urandom);
            for (int i = 0; i < NN; i++)
                case ($urandom_range(0, 3))
                    0: put(b, i, 32'($urandom_range(0, 7)));
                    1: put(b, i, 32'hFFFFFFFF);
                    default: put(b, i, $urandom);
                endcase
            run_scan($sformatf("rand%0d", k), b, k[0] ? $urandom : 32'($urandom_range(0, 8)), k > 2 ? int'($urandom_range(1, 15)) : 0);
        end
        output_addr = 16'h0200;
        target = 32'h0800_0000;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 60 && d2 < 0; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
        end
        start = 1'b0;
        chk("held:first_done", 32'(d1), NN + 3);
        chk("held:second_done", 32'(d2), 2 * (NN + 3) + 2);
        chk("held:nonce", 32'(best_nonce), 15);
        chk("held:hash", best_hash, 32'h1000_0000);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nonce_result_scanner.md
NONCE_RESULT_SCANNER -- requirements
Module: nonce_result_scanner

Interface
REQ-001 SHALL have parameter NUM_NONCES, default 16, giving the number of hash words scanned (range 1..64).
REQ-002 SHALL have parameter RESULT_ADDR, default 16'h0100, giving the writeback base address (used only with the Configuration macro).
REQ-003 clk  in  1  the single clock; all logic is rising-edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 start  in  1  begins a scan; sampled only in IDLE.
REQ-006 output_addr  in  16  base address of the hash words.
REQ-007 target  in  32  difficulty threshold; a hash word qualifies when it is below target.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 found  out  1  at least one qualifying word; valid from done until the next start.
REQ-010 best_nonce  out  6  index of the minimum hash word.
REQ-011 best_hash  out  32  minimum hash word value.
REQ-012 mem_clk  out  1  equals clk.
REQ-013 mem_we  out  1  memory write enable.
REQ-014 mem_addr  out  16  memory address.
REQ-015 mem_write_data  out  32  memory write data.
REQ-016 mem_read_data  in  32  memory read data.

Function
REQ-017 Memory timing: data for a mem_addr value registered at edge k is sampled at edge k+2; the scanner issues reads back-to-back, one address per cycle.
REQ-018 States: IDLE, ISSUE, DRAIN, WB0, WB1, DONE.
- IDLE -> ISSUE on start.
- ISSUE -> DRAIN after NUM_NONCES addresses.
- DRAIN -> DONE, or -> WB0 when writeback is enabled.
- WB0 -> WB1 -> DONE.
- DONE -> IDLE.
REQ-019 At the start edge:
- mem_addr <= output_addr and the read index <= 0.
- best_hash <= 32'hFFFFFFFF, best_nonce <= 0, found <= 0.
REQ-020 In ISSUE, mem_addr increments by 1 per cycle (16-bit, wraps FFFF->0000) until output_addr+NUM_NONCES-1 has been issued.
REQ-021 Each returned word i is compared as unsigned 32-bit.
- If word < best_hash (strict), best_hash <= word and best_nonce <= i.
- Ties keep the lower index.
REQ-022 found SHALL be set when any word i satisfies word < target (strict, unsigned); target = 0 never sets found.
REQ-023 The last word is captured in DRAIN; the comparison completes before leaving DRAIN.
REQ-024 Without writeback, done pulses exactly NUM_NONCES+3 cycles after the start edge (NUM_NONCES=16 -> 19).
REQ-025 done is high for exactly one cycle, in DONE.
REQ-026 found, best_nonce and best_hash hold stable from done until the next accepted start.
REQ-027 start asserted outside IDLE is ignored; start held high re-triggers a scan from IDLE after DONE.
REQ-028 A word equal to 32'hFFFFFFFF never replaces the initial best (best_nonce stays 0 if all words are FFFFFFFF).

Reset
REQ-029 With reset_n=0 at a rising edge, the block SHALL go to IDLE and set: done=0, found=0, best_nonce=0, best_hash=32'hFFFFFFFF, mem_we=0, mem_addr=0, mem_write_data=0.
REQ-030 Reset mid-scan or mid-writeback aborts with no further memory writes; the next start performs a full scan.

Configuration
REQ-031 Macro SCANNER_WRITEBACK_EN.
- When defined:
  - WB0 writes best_hash to RESULT_ADDR with mem_we=1.
  - WB1 writes {found, 25'b0, best_nonce} to RESULT_ADDR+1 with mem_we=1.
  - mem_we returns to 0 in DONE.
  - done latency becomes NUM_NONCES+5.
- When undefined: mem_we and mem_write_data are constant 0, and WB0/WB1 are unreachable.

Verification
REQ-032 Words i -> 32'h1000_0000 + (15-i)·16, target=32'h0800_0000 -> best_nonce=15, best_hash=32'h1000_0000, found=0, done at cycle 19.
REQ-033 Word 5 = 32'h0000_00FF, others 32'hFFFF_0000, target=32'h0001_0000 -> found=1, best_nonce=5, best_hash=32'h0000_00FF.
REQ-034 Words 3 and 9 both 32'h0000_1234, others larger -> best_nonce=3.
REQ-035 output_addr=16'hFFF8 -> addresses FFF8..FFFF then 0000..0007 are read, in order.
REQ-036 Reset_n low at cycle 8 of a scan -> outputs at reset values; a new start gives correct results. With SCANNER_WRITEBACK_EN defined, no mem_we pulse occurs after the reset.
REQ-037 SCANNER_WRITEBACK_EN defined, scenario REQ-033 -> mem[0x0100]=32'h0000_00FF and mem[0x0101]=32'h8000_0005, done at cycle 21.
